// File: rtl/ccm_coeff_sequencer.sv
// Colour-correction matrix sequencer.
// Host words fill a shadow bank of nine coefficients. A complete shadow
// matrix is copied into the active bank only on a frame_start pulse, so the
// conversion stage never sees the matrix change in the middle of a frame.
module ccm_coeff_sequencer #(
  parameter  int INT_BITS  = 6,
  parameter  int FRAC_BITS = 6,
  localparam int CW        = INT_BITS + FRAC_BITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_valid_i,
  input  logic                wr_first_i,
  input  logic [CW-1:0]       wr_data_i,
  output logic                wr_ready_o,
  input  logic                frame_start_i,
  output logic [8:0][CW-1:0]  cc_coeff_o,
  output logic                commit_pending_o,
  output logic                coeff_updated_o,
  output logic                seq_err_o
);

  // Unity gain in the fixed-point format, and the identity matrix built from it.
  localparam logic [CW-1:0] ONE  = CW'(1 << FRAC_BITS);
  localparam logic [CW-1:0] ZERO = '0;
  localparam logic [8:0][CW-1:0] IDENT = {ONE, ZERO, ZERO, ZERO, ONE, ZERO, ZERO, ZERO, ONE};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_PENDING = 2'd2
  } state_e;

  state_e              state_q;
  logic [3:0]          idx_q;
  logic [8:0][CW-1:0]  shadow_q;
  logic [8:0][CW-1:0]  active_q;
  logic                coeff_updated_q;
  logic                seq_err_q;
  logic                xfer;

  // Handshake and status depend on registered state only.
  assign wr_ready_o       = (state_q != S_PENDING);
  assign commit_pending_o = (state_q == S_PENDING);
  assign xfer             = wr_valid_i && wr_ready_o;

  assign cc_coeff_o      = active_q;
  assign coeff_updated_o = coeff_updated_q;
  assign seq_err_o       = seq_err_q;

  // Load sequencer: word counting, shadow writes, abort handling and commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      idx_q           <= 4'd0;
      shadow_q        <= IDENT;
      active_q        <= IDENT;
      coeff_updated_q <= 1'b0;
      seq_err_q       <= 1'b0;
    end else begin
      coeff_updated_q <= 1'b0;
      seq_err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            if (wr_first_i) begin
              shadow_q[0] <= wr_data_i;
              idx_q       <= 4'd1;
              state_q     <= S_LOAD;
            end else begin
              // A word without a preceding first marker has no slot; drop it.
              seq_err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            if (wr_first_i) begin
              // Host restarted the matrix: abandon the partial load and begin again.
              seq_err_q   <= 1'b1;
              shadow_q[0] <= wr_data_i;
              idx_q       <= 4'd1;
            end else begin
              shadow_q[idx_q] <= wr_data_i;
              if (idx_q == 4'd8) begin
                idx_q   <= 4'd0;
                state_q <= S_PENDING;
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end
        end
        S_PENDING: begin
          if (frame_start_i) begin
            active_q        <= shadow_q;
            coeff_updated_q <= 1'b1;
            state_q         <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          idx_q   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/ccm_coeff_sequencer.md
# ccm_coeff_sequencer

Loads a new 3x3 colour-correction matrix from a host word stream into a shadow bank, then commits it to the active bank only at a frame boundary. The active bank drives the `cc_coeff` input of the colorspace conversion stage, so the matrix never changes mid-frame. Sits between the host/config interface and the colorspace conversion block, in the pixel clock domain.

## Interface
- INT_BITS, 6, integer bits of each signed fixed-point coefficient
- FRAC_BITS, 6, fractional bits of each coefficient; CW = INT_BITS+FRAC_BITS
- clk  in  1  pixel clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- wr_valid  in  1  host coefficient word valid
- wr_first  in  1  qualifies wr_valid: this word is coefficient index 0
- wr_data  in  CW  signed coefficient, two's complement, FRAC_BITS fractional
- wr_ready  out  1  block can accept a word
- frame_start  in  1  single-cycle pulse at start of each frame
- cc_coeff  out  9xCW  active matrix, packed signed [8:0][CW-1:0]; index 0-2 red row, 3-5 green row, 6-8 blue row
- commit_pending  out  1  full shadow matrix waiting for frame_start
- coeff_updated  out  1  one-cycle pulse: active bank just changed
- seq_err  out  1  one-cycle pulse: word dropped or partial load aborted

## Operation
- Transfer occurs on a rising edge with wr_valid && wr_ready.
- Word counter idx (0..8); shadow bank of 9 CW-bit registers; active bank of 9 CW-bit registers driving cc_coeff directly (registered, no combinational path from inputs).
- States: IDLE (idx=0, wr_ready=1), LOAD (idx 1..8, wr_ready=1), PENDING (shadow complete, wr_ready=0).
- IDLE: transfer with wr_first=1 -> shadow[0]=wr_data, idx=1, go LOAD. Transfer with wr_first=0 -> word discarded, seq_err pulse, stay IDLE.
- LOAD: transfer with wr_first=0 -> shadow[idx]=wr_data, idx+1; on idx=8 write -> go PENDING, idx=0. Transfer with wr_first=1 -> abort partial load, seq_err pulse, shadow[0]=wr_data, idx=1, stay LOAD.
- PENDING: commit_pending=1; wr_ready=0 (host words held off). frame_start=1 -> active bank <= shadow bank (all 9 simultaneously), go IDLE, coeff_updated=1 next cycle.
- frame_start in IDLE or LOAD: no effect; partial load continues across frame boundary.
- Shadow contents never reach cc_coeff except via commit; aborted/partial loads leave active bank untouched.
- No arithmetic or saturation on coefficients; bits passed verbatim.

## Timing
- Reset (reset=0, async): state IDLE, idx=0, wr_ready=1, commit_pending=0, coeff_updated=0, seq_err=0; active and shadow banks = identity (indices 0,4,8 = 1<<FRAC_BITS, others 0). Reset mid-load or mid-pending discards all shadow data.
- wr_ready, commit_pending are functions of registered state only.
- 9th word accepted on edge N -> commit_pending=1 from cycle N+1; frame_start sampled at edge N is ignored (state was LOAD). Earliest commit edge N+1.
- Commit on edge M -> cc_coeff new value and coeff_updated=1 during cycle M+1; coeff_updated low at M+2 unless another commit.
- seq_err asserted the cycle after the offending edge, for one cycle.
- Back-to-back host words accepted every cycle in IDLE/LOAD; minimum full update = 9 cycles + wait for frame_start.
- wr_valid=0 cycles inside a load are permitted; no timeout.

## Test plan
- Reset check: reset=0 -> cc_coeff[0],[4],[8]=64 (FRAC_BITS=6), others 0; wr_ready=1, all pulses 0.
- Normal load: words 64,-13,5,-20,90,-6,3,-17,78 with wr_first on first, one per cycle -> commit_pending=1 after 9th; cc_coeff unchanged until frame_start pulse, then all 9 values appear next cycle with coeff_updated one-cycle pulse.
- Backpressure: in PENDING drive wr_valid=1 for 20 cycles -> wr_ready=0, no shadow change; after commit wr_ready=1.
- Abort: 4 words, then wr_first word of value 32 + 8 more -> seq_err one pulse at restart; committed matrix index 0 = 32, earlier 4 words absent.
- Stray word: in IDLE send wr_first=0 word -> seq_err pulse, state IDLE, no shadow write.
- Edge cases: frame_start on same edge as 9th word -> no commit; next frame_start commits. Async reset while PENDING -> cc_coeff stays identity, commit_pending=0 immediately.
